display_mode_sequencer: RTL and testbench
=========================================

DISPLAY_MODE_SEQUENCER -- requirements
Module: display_mode_sequencer

Interface
REQ-001 SHALL have parameter DWELL_SEC, default 2: oneHzTick pulses per automatic mode advance (range 1-15).
REQ-002 SHALL have parameter LOCKOUT_CYC, default 4: clk cycles after an accepted button press during which further presses are ignored.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level; 1 = sequencer running, 0 = idle.
REQ-006 SHALL have port holdSwitch  input  1  level; 1 = freeze automatic rotation.
REQ-007 SHALL have port modeButton  input  1  raw, asynchronous push-button.
REQ-008 SHALL have port oneHzTick  input  1  single-cycle pulse once per second.
REQ-009 SHALL have port enableMask  input  4  bit i = 1 allows MODE i (0 totalSteps, 1 distanceCovered, 2 thirtyTwoStepsPerSecond, 3 sixtyFourStepsPerSecond).
REQ-010 SHALL have port MODE  output  3  registered select to the 14-bit display mux; only values 0-3 are ever driven.
REQ-011 SHALL have port modeChanged  output  1  one-cycle pulse in the cycle after MODE changes value.
REQ-012 SHALL have port dwellCount  output  4  registered seconds elapsed in the current mode.

Function
REQ-013 SHALL pass modeButton through a 2-flop synchronizer, then rising-edge detect; the detected edge is "press".
REQ-014 SHALL ignore any press while the lockout counter is nonzero; an accepted press loads the counter with LOCKOUT_CYC, which then decrements by 1 per cycle to 0.
REQ-015 SHALL implement states IDLE, ROTATE, HOLD.
REQ-016 IDLE: MODE=0, dwellCount=0, presses ignored; start=1 -> ROTATE (holdSwitch=0) or HOLD (holdSwitch=1) on the next edge.
REQ-017 ROTATE: dwellCount increments on each oneHzTick; when a tick would make dwellCount reach DWELL_SEC, MODE advances and dwellCount clears to 0 instead.
REQ-018 HOLD: dwellCount and automatic advance frozen; accepted presses still advance MODE and clear dwellCount.
REQ-019 ROTATE<->HOLD SHALL follow holdSwitch with one cycle latency; any state with start=0 -> IDLE next edge.
REQ-020 An accepted press in ROTATE or HOLD SHALL advance MODE on the edge after detection and clear dwellCount.
REQ-021 Advance SHALL select the first mode i with enableMask[i]=1 searching cyclically from MODE+1 (3 wraps to 0); if no other mode is enabled, MODE is unchanged.
REQ-022 If enableMask=0000, MODE SHALL be forced to 0 and all advances suppressed.
REQ-023 If enableMask[MODE] becomes 0 outside IDLE, MODE SHALL move to the next enabled mode per REQ-021 on the following edge, in ROTATE or HOLD, clearing dwellCount.
REQ-024 Simultaneous dwell expiry and accepted press in one cycle SHALL produce exactly one advance.
REQ-025 modeChanged SHALL pulse for every MODE value change, including return to 0 on entering IDLE; never when MODE is unchanged.
REQ-026 dwellCount SHALL never exceed DWELL_SEC-1.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, MODE=0, dwellCount=0, modeChanged=0, lockout counter=0, synchronizer flops=0.
REQ-028 Reset mid-rotation SHALL discard the press in flight; the first cycle after release behaves as IDLE.

Verification
REQ-029 mask=1111, start=1, hold=0, DWELL_SEC=2, 8 ticks -> MODE 0,1,2,3,0 advancing every 2nd tick; modeChanged pulses 4 times.
REQ-030 mask=0101, press 3 times with gaps >LOCKOUT_CYC -> MODE 0->2->0->2; modes 1 and 3 never appear.
REQ-031 Two presses 2 cycles apart (LOCKOUT_CYC=4) -> single advance 0->1.
REQ-032 hold=1, 10 ticks -> MODE stays 0, dwellCount stays 0; one press -> MODE=1.
REQ-033 MODE=2, tick at dwellCount=1 coinciding with press -> MODE=3 (not 0), dwellCount=0.
REQ-034 MODE=3, assert reset_n=0 mid-cycle -> MODE=0 without waiting for clk; mask=0000 after release -> MODE remains 0 despite ticks and presses.

Source files
------------

// File: rtl/display_mode_sequencer_if.sv
// Control inputs and display-select outputs of the display mode sequencer.
interface display_mode_sequencer_if;
    logic       start;
    logic       holdSwitch;
    logic       modeButton;
    logic       oneHzTick;
    logic [3:0] enableMask;
    logic [2:0] MODE;
    logic       modeChanged;
    logic [3:0] dwellCount;

    modport master (
        output start, holdSwitch, modeButton, oneHzTick, enableMask,
        input  MODE, modeChanged, dwellCount
    );

    modport slave (
        input  start, holdSwitch, modeButton, oneHzTick, enableMask,
        output MODE, modeChanged, dwellCount
    );
endinterface

// File: rtl/display_mode_sequencer.sv
// Rotates the display mux select through enabled modes on a seconds dwell,
// with hold, a debounced-by-lockout manual advance button and mask tracking.
module display_mode_sequencer #(
    parameter int DWELL_SEC   = 2,
    parameter int LOCKOUT_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    display_mode_sequencer_if.slave  bus
);

    localparam int         LW         = (LOCKOUT_CYC < 1) ? 1 : $clog2(LOCKOUT_CYC + 1);
    localparam logic [3:0] DWELL_LAST = 4'(DWELL_SEC - 1);

    typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_btn_s1;
    logic          r_btn_s2;
    logic          r_btn_d;
    logic [LW-1:0] r_lock;
    logic [1:0]    r_mode;
    logic [1:0]    w_mode_nxt;
    logic [1:0]    w_mode_adv;
    logic [3:0]    r_dwell;
    logic [3:0]    w_dwell_nxt;
    logic          r_changed;
    logic          w_press;
    logic          w_accept;

    // Lowest cyclic distance wins; with no other enabled mode the current one is kept.
    function automatic logic [1:0] f_next_mode(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        res = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    assign w_press    = r_btn_s2 & ~r_btn_d;
    assign w_accept   = w_press && (r_lock == '0) && (r_state != IDLE) && bus.start;
    assign w_mode_adv = f_next_mode(r_mode, bus.enableMask);

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_dwell_nxt = r_dwell;

        if (!bus.start)           w_state_nxt = IDLE;
        else if (bus.holdSwitch)  w_state_nxt = HOLD;
        else                      w_state_nxt = ROTATE;

        if (r_state == IDLE || w_state_nxt == IDLE) begin
            w_mode_nxt  = 2'd0;
            w_dwell_nxt = 4'd0;
        end else if (bus.enableMask == 4'b0000) begin
            w_mode_nxt  = 2'd0;
            w_dwell_nxt = 4'd0;
        end else if (!bus.enableMask[r_mode] || w_accept) begin
            w_mode_nxt  = w_mode_adv;
            w_dwell_nxt = 4'd0;
        end else if (r_state == ROTATE && bus.oneHzTick) begin
            // Expiry advances instead of letting the count reach DWELL_SEC.
            if (r_dwell >= DWELL_LAST) begin
                w_mode_nxt  = w_mode_adv;
                w_dwell_nxt = 4'd0;
            end else begin
                w_dwell_nxt = r_dwell + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_btn_d   <= 1'b0;
            r_lock    <= '0;
            r_mode    <= 2'd0;
            r_dwell   <= 4'd0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_btn_s1  <= bus.modeButton;
            r_btn_s2  <= r_btn_s1;
            r_btn_d   <= r_btn_s2;
            if (w_accept)          r_lock <= LW'(LOCKOUT_CYC);
            else if (r_lock != '0) r_lock <= r_lock - 1'b1;
            r_mode    <= w_mode_nxt;
            r_dwell   <= w_dwell_nxt;
            r_changed <= (w_mode_nxt != r_mode);
        end
    end

    assign bus.MODE        = {1'b0, r_mode};
    assign bus.modeChanged = r_changed;
    assign bus.dwellCount  = r_dwell;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed table and corner-case sequences for display_mode_sequencer.
module tb_display_mode_sequencer;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    display_mode_sequencer_if bus();

    display_mode_sequencer #(.DWELL_SEC(2), .LOCKOUT_CYC(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int start;
        int hold;
        int btn;
        int tick;
        int mask;
        int mode;
        int chg;
        int dwell;
    } vec_t;

    vec_t rows [24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Button is seen by the FSM two edges after it is driven; MODE moves on the third.
    task automatic press_chk(input string nm, input int exp_mode);
        bus.modeButton = 1'b1;
        step();
        bus.modeButton = 1'b0;
        step();
        step();
        chk({nm, "_mode"}, int'(bus.MODE), exp_mode);
        chk({nm, "_chg"}, int'(bus.modeChanged), 1);
        chk({nm, "_dwell"}, int'(bus.dwellCount), 0);
        repeat (6) step();
        chk({nm, "_settled"}, int'(bus.MODE), exp_mode);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //           start hold btn tick mask     mode chg dwell
        rows[0]  = '{1, 0, 0, 0, 4'b1111, 0, 0, 0};
        rows[1]  = '{1, 0, 0, 1, 4'b1111, 0, 0, 1};
        rows[2]  = '{1, 0, 0, 0, 4'b1111, 0, 0, 1};
        rows[3]  = '{1, 0, 0, 1, 4'b1111, 1, 1, 0};
        rows[4]  = '{1, 0, 0, 0, 4'b1111, 1, 0, 0};
        rows[5]  = '{1, 0, 0, 1, 4'b1111, 1, 0, 1};
        rows[6]  = '{1, 0, 0, 1, 4'b1111, 2, 1, 0};
        rows[7]  = '{1, 0, 0, 1, 4'b1111, 2, 0, 1};
        rows[8]  = '{1, 0, 0, 1, 4'b1111, 3, 1, 0};
        rows[9]  = '{1, 0, 0, 1, 4'b1111, 3, 0, 1};
        rows[10] = '{1, 0, 0, 1, 4'b1111, 0, 1, 0};
        rows[11] = '{1, 1, 0, 0, 4'b1111, 0, 0, 0};
        rows[12] = '{1, 1, 0, 1, 4'b1111, 0, 0, 0};
        rows[13] = '{1, 1, 0, 1, 4'b1111, 0, 0, 0};
        rows[14] = '{1, 1, 0, 0, 4'b1110, 1, 1, 0};
        rows[15] = '{1, 0, 0, 0, 4'b1110, 1, 0, 0};
        rows[16] = '{1, 0, 0, 1, 4'b1110, 1, 0, 1};
        rows[17] = '{1, 0, 0, 0, 4'b0000, 0, 1, 0};
        rows[18] = '{1, 0, 0, 1, 4'b0000, 0, 0, 0};
        rows[19] = '{1, 0, 0, 0, 4'b1000, 3, 1, 0};
        rows[20] = '{1, 0, 0, 1, 4'b1000, 3, 0, 1};
        rows[21] = '{1, 0, 0, 1, 4'b1000, 3, 0, 0};
        rows[22] = '{0, 0, 0, 0, 4'b1000, 0, 1, 0};
        rows[23] = '{0, 0, 0, 0, 4'b1000, 0, 0, 0};

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.holdSwitch = 1'b0;
        bus.modeButton = 1'b0;
        bus.oneHzTick  = 1'b0;
        bus.enableMask = 4'b1111;
        repeat (2) step();
        chk("rst_mode", int'(bus.MODE), 0);
        chk("rst_chg", int'(bus.modeChanged), 0);
        chk("rst_dwell", int'(bus.dwellCount), 0);
        reset_n = 1'b1;
        step();
        chk("idle_mode", int'(bus.MODE), 0);

        // Rotation, hold freeze, mask tracking, empty mask, stop to idle
        for (int i = 0; i < 24; i++) begin
            bus.start      = rows[i].start[0];
            bus.holdSwitch = rows[i].hold[0];
            bus.modeButton = rows[i].btn[0];
            bus.oneHzTick  = rows[i].tick[0];
            bus.enableMask = 4'(rows[i].mask);
            step();
            chk($sformatf("row%0d_mode", i), int'(bus.MODE), rows[i].mode);
            chk($sformatf("row%0d_chg", i), int'(bus.modeChanged), rows[i].chg);
            chk($sformatf("row%0d_dwell", i), int'(bus.dwellCount), rows[i].dwell);
        end
        bus.oneHzTick = 1'b0;

        // Sparse mask: presses alternate between modes 0 and 2
        bus.enableMask = 4'b0101;
        bus.start      = 1'b1;
        bus.holdSwitch = 1'b1;
        repeat (2) step();
        press_chk("mask0101_p1", 2);
        press_chk("mask0101_p2", 0);
        press_chk("mask0101_p3", 2);

        // Second press inside the lockout window is ignored
        bus.start = 1'b0;
        repeat (2) step();
        chk("stop_mode", int'(bus.MODE), 0);
        bus.enableMask = 4'b1111;
        bus.start      = 1'b1;
        repeat (2) step();
        bus.modeButton = 1'b1;
        step();
        bus.modeButton = 1'b0;
        step();
        bus.modeButton = 1'b1;
        step();
        chk("lock_first", int'(bus.MODE), 1);
        bus.modeButton = 1'b0;
        repeat (2) step();
        chk("lock_second_mode", int'(bus.MODE), 1);
        chk("lock_second_chg", int'(bus.modeChanged), 0);
        repeat (4) step();
        chk("lock_settled", int'(bus.MODE), 1);

        // Hold ignores ticks, still honours a press
        bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1;
        repeat (2) step();
        for (int t = 0; t < 10; t++) begin
            bus.oneHzTick = 1'b1;
            step();
            bus.oneHzTick = 1'b0;
            step();
            chk($sformatf("hold_t%0d_mode", t), int'(bus.MODE), 0);
            chk($sformatf("hold_t%0d_dwell", t), int'(bus.dwellCount), 0);
        end
        press_chk("hold_press", 1);

        // Dwell expiry coinciding with a press gives one advance
        bus.holdSwitch = 1'b0;
        step();
        bus.oneHzTick = 1'b1;
        step();
        step();
        step();
        bus.oneHzTick = 1'b0;
        chk("coin_pre_mode", int'(bus.MODE), 2);
        chk("coin_pre_dwell", int'(bus.dwellCount), 1);
        bus.modeButton = 1'b1;
        step();
        bus.modeButton = 1'b0;
        step();
        chk("coin_wait_dwell", int'(bus.dwellCount), 1);
        bus.oneHzTick = 1'b1;
        step();
        bus.oneHzTick = 1'b0;
        chk("coin_mode", int'(bus.MODE), 3);
        chk("coin_dwell", int'(bus.dwellCount), 0);
        chk("coin_chg", int'(bus.modeChanged), 1);
        step();
        chk("coin_after_mode", int'(bus.MODE), 3);
        chk("coin_after_chg", int'(bus.modeChanged), 0);

        // Asynchronous reset between edges, then an all-disabled mask
        #2;
        reset_n        = 1'b0;
        bus.modeButton = 1'b1;
        #1;
        chk("async_rst_mode", int'(bus.MODE), 0);
        chk("async_rst_dwell", int'(bus.dwellCount), 0);
        chk("async_rst_chg", int'(bus.modeChanged), 0);
        bus.enableMask = 4'b0000;
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.oneHzTick  = (c % 2 == 0);
            bus.modeButton = ((c / 3) % 2 == 0);
            step();
            chk($sformatf("mask0_c%0d_mode", c), int'(bus.MODE), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
